mem_strb: RTL and testbench

//  Parametrised single-clock RAM with one read port and one write port, byte-addressed.

---
 rtl/mem_strb.sv | 101 ++++++++++
 tb/tb_mem_strb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_strb.sv
// mem_strb: single-clock byte-addressed RAM with one read port and one write port.
//   Write port: per-byte strobes; the write is always accepted and w_err_o pulses
//   for one cycle when it is rejected (misaligned or out of range).
//   Read port: valid/ready request with a response that holds until r_ack_i.
//   A rejected read returns r_err_o=1 with r_data_o=0.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   r_req_i/r_rdy_o/r_addr_i       read request handshake and byte address
//   r_vld_o/r_ack_i/r_data_o/r_err_o  held read response
//   w_en_i/w_addr_i/w_data_i/w_strb_i  strobed write
//   w_err_o                        one-cycle rejected-write pulse
// Build option: define MEM_STRB_WR_FWD_EN so that a read of the word being written
//   in the same cycle returns the merged word. Without it the read returns the old word.
module mem_strb #(
  parameter int DATA_W    = 32,
  parameter int ROWS      = 512,
  parameter int ADDR_W    = 32,
  parameter     DATA_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                r_req_i,
  output logic                r_rdy_o,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic                r_vld_o,
  input  logic                r_ack_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic                r_err_o,
  input  logic                w_en_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  output logic                w_err_o
);
  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [DATA_W-1:0] mem [ROWS];

  // Address decode: word index is the byte address with the lane bits dropped.
  logic [ADDR_W-1:0] r_word, w_word;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic              r_bad, w_bad;

  assign r_word = r_addr_i >> LB;
  assign w_word = w_addr_i >> LB;
  assign r_idx  = r_word[IDX_W-1:0];
  assign w_idx  = w_word[IDX_W-1:0];
  assign r_bad  = (r_addr_i[LB-1:0] != '0) || (r_word >= ADDR_W'(ROWS));
  assign w_bad  = (w_addr_i[LB-1:0] != '0) || (w_word >= ADDR_W'(ROWS));

  // Held response: a new request may enter when nothing is held or the held one
  // is being consumed this cycle.
  logic r_acc;
  assign r_rdy_o = !r_vld_o || r_ack_i;
  assign r_acc   = r_req_i && r_rdy_o;

  // Word returned to an accepted read. Forwarding only applies to a good write
  // hitting the same word as a good read.
  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = mem[r_idx];
`ifdef MEM_STRB_WR_FWD_EN
    if (w_en_i && !w_bad && !r_bad && (w_idx == r_idx)) begin
      for (int k = 0; k < NB; k++) begin
        if (w_strb_i[k]) rd_word[8*k +: 8] = w_data_i[8*k +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_o  <= 1'b0;
      r_err_o  <= 1'b0;
      r_data_o <= '0;
      w_err_o  <= 1'b0;
    end else begin
      w_err_o <= w_en_i && w_bad;
      if (r_acc) begin
        r_vld_o  <= 1'b1;
        r_err_o  <= r_bad;
        r_data_o <= r_bad ? '0 : rd_word;
      end else if (r_ack_i) begin
        // Consumed with no follow-on request; data keeps its last value.
        r_vld_o <= 1'b0;
      end
    end
  end

  // Array is not reset; only strobed lanes of a good write change.
  always_ff @(posedge clk_i) begin
    if (w_en_i && !w_bad) begin
      for (int k = 0; k < NB; k++) begin
        if (w_strb_i[k]) mem[w_idx][8*k +: 8] <= w_data_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_strb.sv
module tb_mem_strb;
  localparam int ROWS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req, r_rdy, r_vld, r_ack, r_err;
  logic [31:0] r_addr, r_data;
  logic        w_en, w_err;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;

  int n_cmp = 0;
  int n_bad = 0;
  bit go = 0;

  mem_strb #(.DATA_W(32), .ROWS(ROWS), .ADDR_W(32), .DATA_FILE("")) dut (
    .clk_i(clk), .rst_i(rst),
    .r_req_i(r_req), .r_rdy_o(r_rdy), .r_addr_i(r_addr),
    .r_vld_o(r_vld), .r_ack_i(r_ack), .r_data_o(r_data), .r_err_o(r_err),
    .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_err_o(w_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: word array plus the currently held response.
  logic [31:0] mm [ROWS];
  logic        m_vld = 0, m_err = 0, m_werr = 0;
  logic [31:0] m_data = 0;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= ROWS);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_vld = 0; m_err = 0; m_data = 0; m_werr = 0;
    end else begin
      automatic bit acc = r_req && (!m_vld || r_ack);
      if (acc) begin
        m_vld = 1;
        if (bad_addr(r_addr)) begin
          m_err = 1; m_data = 0;
        end else begin
          m_err = 0; m_data = mm[r_addr / 4];
`ifdef MEM_STRB_WR_FWD_EN
          if (w_en && !bad_addr(w_addr) && (w_addr == r_addr))
            for (int k = 0; k < 4; k++)
              if (w_strb[k]) m_data[8*k +: 8] = w_data[8*k +: 8];
`endif
        end
      end else if (r_ack) m_vld = 0;
      m_werr = w_en && bad_addr(w_addr);
      if (w_en && !bad_addr(w_addr))
        for (int k = 0; k < 4; k++)
          if (w_strb[k]) mm[w_addr / 4][8*k +: 8] = w_data[8*k +: 8];
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (go) begin
      chk("m_vld", {31'b0, r_vld}, {31'b0, m_vld});
      chk("m_rdy", {31'b0, r_rdy}, {31'b0, (!m_vld || r_ack)});
      chk("m_werr", {31'b0, w_err}, {31'b0, m_werr});
      if (m_vld) begin
        chk("m_data", r_data, m_data);
        chk("m_err", {31'b0, r_err}, {31'b0, m_err});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    w_en = 1; w_addr = a; w_data = d; w_strb = s;
    step();
    w_en = 0;
  endtask

  // Issue one read, check the response literally, then consume it.
  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] d, input logic e);
    r_req = 1; r_addr = a; r_ack = 0;
    step();
    r_req = 0;
    chk({nm, "_vld"}, {31'b0, r_vld}, 32'd1);
    chk({nm, "_data"}, r_data, d);
    chk({nm, "_err"}, {31'b0, r_err}, {31'b0, e});
    r_ack = 1;
    step();
    r_ack = 0;
  endtask

  initial begin
    rst = 1; r_req = 0; r_addr = 0; r_ack = 0;
    w_en = 0; w_addr = 0; w_data = 0; w_strb = 0;
    step(); step();
    go = 1;
    chk("rst_vld", {31'b0, r_vld}, 32'd0);
    chk("rst_err", {31'b0, r_err}, 32'd0);
    chk("rst_data", r_data, 32'd0);
    chk("rst_werr", {31'b0, w_err}, 32'd0);
    rst = 0;

    // Preload: word i = 0x5A000000 + i*0x00010203.
    for (int i = 0; i < 32; i++) wr(32'(i * 4), 32'h5A00_0000 + 32'(i) * 32'h0001_0203, 4'hF);
    wr(32'h00, 32'hDEAD_BEEF, 4'hF);
    wr(32'h10, 32'hAABB_CCDD, 4'hF);
    wr(32'h20, 32'h0000_0000, 4'hF);

    // 1: plain read
    rd("t1", 32'h0, 32'hDEAD_BEEF, 0);

    // 2: strobed write
    wr(32'h10, 32'h1122_3344, 4'b0101);
    rd("t2", 32'h10, 32'hAA22_CC44, 0);

    // 3: read errors, back-to-back via ack+request
    r_req = 1; r_addr = 32'h12; r_ack = 0;
    step();
    chk("t3_mis_err", {31'b0, r_err}, 32'd1);
    chk("t3_mis_data", r_data, 32'd0);
    r_addr = ROWS * 4; r_ack = 1;
    step();
    r_req = 0;
    chk("t3_oor_vld", {31'b0, r_vld}, 32'd1);
    chk("t3_oor_err", {31'b0, r_err}, 32'd1);
    chk("t3_oor_data", r_data, 32'd0);
    step();
    r_ack = 0;
    chk("t3_drain", {31'b0, r_vld}, 32'd0);
    // write error and zero-strobe no-op
    wr(32'h13, 32'hFFFF_FFFF, 4'hF);
    chk("t3_werr", {31'b0, w_err}, 32'd1);
    wr(32'h0, 32'h0, 4'h0);
    chk("t3_werr_pulse", {31'b0, w_err}, 32'd0);
    wr(32'h0, 32'h0, 4'h0);
    rd("t3_keep", 32'h10, 32'hAA22_CC44, 0);
    rd("t3_nostrb", 32'h0, 32'hDEAD_BEEF, 0);

    // 4: stall then back-to-back
    r_req = 1; r_addr = 32'h40; r_ack = 0;
    step();
    r_addr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_rdy", {31'b0, r_rdy}, 32'd0);
      chk("t4_stall_data", r_data, 32'h5A10_2030);
      step();
    end
    r_ack = 1;
    #1;
    chk("t4_ack_rdy", {31'b0, r_rdy}, 32'd1);
    step();
    chk("t4_b2b0", r_data, 32'h5A11_2233);
    r_addr = 32'h48; step();
    chk("t4_b2b1", r_data, 32'h5A12_2436);
    r_addr = 32'h4C; step();
    chk("t4_b2b2", r_data, 32'h5A13_2639);
    r_addr = 32'h50; step();
    chk("t4_b2b3", r_data, 32'h5A14_283C);
    chk("t4_b2b3_vld", {31'b0, r_vld}, 32'd1);
    r_req = 0; step();
    r_ack = 0;

    // 5: same-cycle write/read of one word
    w_en = 1; w_addr = 32'h20; w_data = 32'hFFFF_FFFF; w_strb = 4'hF;
    r_req = 1; r_addr = 32'h20;
    step();
    w_en = 0; r_req = 0;
`ifdef MEM_STRB_WR_FWD_EN
    chk("t5_same", r_data, 32'hFFFF_FFFF);
`else
    chk("t5_same", r_data, 32'h0000_0000);
`endif
    r_ack = 1; step(); r_ack = 0;
    rd("t5_later", 32'h20, 32'hFFFF_FFFF, 0);

    // 6: reset with a held response and a bad write in flight
    r_req = 1; r_addr = 32'h0;
    step();
    r_req = 0;
    chk("t6_pre_vld", {31'b0, r_vld}, 32'd1);
    rst = 1; w_en = 1; w_addr = 32'h13; w_strb = 4'hF;
    step();
    chk("t6_vld", {31'b0, r_vld}, 32'd0);
    chk("t6_rdy", {31'b0, r_rdy}, 32'd1);
    chk("t6_werr", {31'b0, w_err}, 32'd0);
    rst = 0; w_en = 0;
    step();
    rd("t6_after", 32'h0, 32'hDEAD_BEEF, 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
